// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: latches a BCD HHMM alarm, rings on time match,
// handles stop / snooze (BCD +SNOOZE_MIN, 24h wrap) / ring timeout.
// Ports:
//   clk, resetn (async, active low), enable (alarm on/off level)
//   finish2 + alarm[15:0]: alarm load pulse and BCD {H1,H0,M1,M0}
//   time_now[15:0]: BCD current time; sec_tick: 1 Hz pulse
//   push_stop, push_snooze: debounced button pulses
//   ring, ring_led, state[1:0], target[15:0], alarm_err: registered outputs
module alarm_ring_ctrl #(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_MIN     = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        finish2,
  input  logic [15:0] alarm,
  input  logic [15:0] time_now,
  input  logic        sec_tick,
  input  logic        push_stop,
  input  logic        push_snooze,
  output logic        ring,
  output logic        ring_led,
  output logic [1:0]  state,
  output logic [15:0] target,
  output logic        alarm_err
);

  localparam int CW = $clog2(RING_TIMEOUT_S + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    RINGING = 2'b10,
    SNOOZE  = 2'b11
  } st_t;

  st_t          st;
  logic [15:0]  alarm_reg;
  logic         valid;
  logic         match_q;
  logic [CW-1:0] cnt;

  logic         alarm_ok;
  logic         load;
  logic         eq;
  logic         hit;
  logic         timeout;

  logic [6:0]   min_sum;
  logic [4:0]   hr;
  logic [4:0]   hr_nx;
  logic [5:0]   min_nx;
  logic [15:0]  snoozed;

  assign state = st;

  assign alarm_ok = (alarm[15:12] <= 4'd2)
                 && (alarm[11:8] <= 4'd9)
                 && ((alarm[15:12] != 4'd2)
                     || (alarm[11:8] <= 4'd3))
                 && (alarm[7:4] <= 4'd5)
                 && (alarm[3:0] <= 4'd9);

  assign load = finish2 && alarm_ok;

  // Edge-detected equality: a ring starts only when the
  // time becomes equal to the target, never while it stays.
  assign eq  = (time_now == target);
  assign hit = eq && !match_q;

  assign timeout = sec_tick
                && (cnt == CW'(RING_TIMEOUT_S - 1));

  // Snooze target: binary minute/hour arithmetic, then
  // re-encoded to BCD.
  always_comb begin
    min_sum = 7'(target[7:4]) * 7'd10
            + 7'(target[3:0])
            + 7'(SNOOZE_MIN);
    hr      = 5'(target[15:12]) * 5'd10
            + 5'(target[11:8]);
    min_nx  = 6'(min_sum);
    hr_nx   = hr;
    if (min_sum >= 7'd60) begin
      min_nx = 6'(min_sum - 7'd60);
      hr_nx  = (hr == 5'd23) ? 5'd0 : hr + 5'd1;
    end
    snoozed = {4'(hr_nx / 5'd10),
               4'(hr_nx % 5'd10),
               4'(min_nx / 6'd10),
               4'(min_nx % 6'd10)};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st        <= IDLE;
      ring      <= 1'b0;
      ring_led  <= 1'b0;
      target    <= 16'h0000;
      alarm_reg <= 16'h0000;
      valid     <= 1'b0;
      alarm_err <= 1'b0;
      match_q   <= 1'b1;
      cnt       <= '0;
    end else begin
      alarm_err <= finish2 && !alarm_ok;
      match_q   <= eq;

      if (load) begin
        alarm_reg <= alarm;
        valid     <= 1'b1;
      end

      if (!enable) begin
        st       <= IDLE;
        ring     <= 1'b0;
        ring_led <= 1'b0;
        if (load) begin
          target  <= alarm;
          match_q <= 1'b1;
        end else begin
          target <= alarm_reg;
        end
      end else if (load) begin
        // Also cancels an active ring or snooze.
        st       <= ARMED;
        target   <= alarm;
        match_q  <= 1'b1;
        ring     <= 1'b0;
        ring_led <= 1'b0;
      end else begin
        unique case (st)
          IDLE: begin
            if (valid) begin
              st      <= ARMED;
              match_q <= 1'b1;
            end
          end
          ARMED: begin
            if (hit) begin
              st       <= RINGING;
              cnt      <= '0;
              ring     <= 1'b1;
              ring_led <= 1'b1;
            end
          end
          RINGING: begin
            if (push_stop) begin
              st       <= ARMED;
              target   <= alarm_reg;
              ring     <= 1'b0;
              ring_led <= 1'b0;
            end else if (push_snooze) begin
              st       <= SNOOZE;
              target   <= snoozed;
              ring     <= 1'b0;
              ring_led <= 1'b0;
            end else if (timeout) begin
              st       <= ARMED;
              target   <= alarm_reg;
              ring     <= 1'b0;
              ring_led <= 1'b0;
            end else if (sec_tick) begin
              cnt      <= cnt + 1'b1;
              ring_led <= !ring_led;
            end
          end
          SNOOZE: begin
            if (push_stop) begin
              st     <= ARMED;
              target <= alarm_reg;
            end else if (hit) begin
              st       <= RINGING;
              cnt      <= '0;
              ring     <= 1'b1;
              ring_led <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl: scoreboard bench for alarm_ring_ctrl.
// Expected outputs are queued with each stimulus cycle.
module tb_alarm_ring_ctrl;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] ARMED = 2'b01;
  localparam logic [1:0] RING  = 2'b10;
  localparam logic [1:0] SNZ   = 2'b11;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        finish2;
  logic [15:0] alarm;
  logic [15:0] time_now;
  logic        sec_tick;
  logic        push_stop;
  logic        push_snooze;
  logic        ring;
  logic        ring_led;
  logic [1:0]  state;
  logic [15:0] target;
  logic        alarm_err;

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic        rg;
    logic        led;
    logic [15:0] tgt;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  alarm_ring_ctrl #(
    .RING_TIMEOUT_S(60),
    .SNOOZE_MIN(5)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .finish2(finish2),
    .alarm(alarm),
    .time_now(time_now),
    .sec_tick(sec_tick),
    .push_stop(push_stop),
    .push_snooze(push_snooze),
    .ring(ring),
    .ring_led(ring_led),
    .state(state),
    .target(target),
    .alarm_err(alarm_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic chk_all(input string tag,
                         input logic [1:0] s,
                         input logic r,
                         input logic l,
                         input logic [15:0] t,
                         input logic e);
    check({tag, ".state"}, 32'(state), 32'(s));
    check({tag, ".ring"}, 32'(ring), 32'(r));
    check({tag, ".led"}, 32'(ring_led), 32'(l));
    check({tag, ".target"}, 32'(target), 32'(t));
    check({tag, ".err"}, 32'(alarm_err), 32'(e));
  endtask

  // Inputs are already driven; queue the expectation,
  // clock once, then pop and compare.
  task automatic cyc(input string tag,
                     input logic [1:0] s,
                     input logic r,
                     input logic l,
                     input logic [15:0] t,
                     input logic e);
    exp_t x;
    x.tag = tag;
    x.st  = s;
    x.rg  = r;
    x.led = l;
    x.tgt = t;
    x.err = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      chk_all(x.tag, x.st, x.rg, x.led, x.tgt, x.err);
    end
    finish2     = 1'b0;
    sec_tick    = 1'b0;
    push_stop   = 1'b0;
    push_snooze = 1'b0;
  endtask

  initial begin
    resetn      = 1'b0;
    enable      = 1'b0;
    finish2     = 1'b0;
    alarm       = 16'h0000;
    time_now    = 16'h0000;
    sec_tick    = 1'b0;
    push_stop   = 1'b0;
    push_snooze = 1'b0;
    #3;
    chk_all("reset", IDLE, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // 1: load 09:38, step time 09:37 -> 09:38
    enable   = 1'b1;
    time_now = 16'h0937;
    alarm    = 16'h0938;
    finish2  = 1'b1;
    cyc("t1_load", ARMED, 0, 0, 16'h0938, 0);
    cyc("t1_wait", ARMED, 0, 0, 16'h0938, 0);
    time_now = 16'h0938;
    cyc("t1_ring", RING, 1, 1, 16'h0938, 0);

    // 2: snooze, re-ring at 09:43, stop
    push_snooze = 1'b1;
    cyc("t2_snz", SNZ, 0, 0, 16'h0943, 0);
    cyc("t2_hold", SNZ, 0, 0, 16'h0943, 0);
    time_now = 16'h0943;
    cyc("t2_ring", RING, 1, 1, 16'h0943, 0);
    push_stop = 1'b1;
    cyc("t2_stop", ARMED, 0, 0, 16'h0938, 0);

    // 4: ring timeout after 60 sec_ticks
    cyc("t4_arm", ARMED, 0, 0, 16'h0938, 0);
    time_now = 16'h0938;
    cyc("t4_ring", RING, 1, 1, 16'h0938, 0);
    for (int k = 1; k <= 60; k++) begin
      sec_tick = 1'b1;
      if (k < 60)
        cyc($sformatf("t4_tick%0d", k), RING, 1,
            ((k % 2) == 0), 16'h0938, 0);
      else
        cyc("t4_timeout", ARMED, 0, 0, 16'h0938, 0);
    end
    cyc("t4_quiet", ARMED, 0, 0, 16'h0938, 0);
    time_now = 16'h0939;
    cyc("t4_rearm", ARMED, 0, 0, 16'h0938, 0);
    time_now = 16'h0938;
    cyc("t4_ring2", RING, 1, 1, 16'h0938, 0);
    push_stop   = 1'b1;
    push_snooze = 1'b1;
    cyc("t4_both", ARMED, 0, 0, 16'h0938, 0);

    // 3: snooze wrap 23:58 -> 00:03 and 09:57 -> 10:02
    time_now = 16'h2357;
    alarm    = 16'h2358;
    finish2  = 1'b1;
    cyc("t3_load", ARMED, 0, 0, 16'h2358, 0);
    cyc("t3_wait", ARMED, 0, 0, 16'h2358, 0);
    time_now = 16'h2358;
    cyc("t3_ring", RING, 1, 1, 16'h2358, 0);
    push_snooze = 1'b1;
    cyc("t3_wrap", SNZ, 0, 0, 16'h0003, 0);
    time_now = 16'h0956;
    alarm    = 16'h0957;
    finish2  = 1'b1;
    cyc("t3_load2", ARMED, 0, 0, 16'h0957, 0);
    cyc("t3_wait2", ARMED, 0, 0, 16'h0957, 0);
    time_now = 16'h0957;
    cyc("t3_ring2", RING, 1, 1, 16'h0957, 0);
    push_snooze = 1'b1;
    cyc("t3_hour", SNZ, 0, 0, 16'h1002, 0);
    time_now  = 16'h1000;
    push_stop = 1'b1;
    cyc("t3_stop", ARMED, 0, 0, 16'h0957, 0);

    // 5: invalid alarms, then alarm equal to current time
    alarm   = 16'h2460;
    finish2 = 1'b1;
    cyc("t5_bad2460", ARMED, 0, 0, 16'h0957, 1);
    alarm   = 16'h0975;
    finish2 = 1'b1;
    cyc("t5_bad0975", ARMED, 0, 0, 16'h0957, 1);
    cyc("t5_errclr", ARMED, 0, 0, 16'h0957, 0);
    alarm   = 16'h2400;
    finish2 = 1'b1;
    cyc("t5_bad2400", ARMED, 0, 0, 16'h0957, 1);
    alarm   = 16'h1000;
    finish2 = 1'b1;
    cyc("t5_loadeq", ARMED, 0, 0, 16'h1000, 0);
    cyc("t5_noring", ARMED, 0, 0, 16'h1000, 0);
    cyc("t5_noring2", ARMED, 0, 0, 16'h1000, 0);
    time_now = 16'h1001;
    cyc("t5_away", ARMED, 0, 0, 16'h1000, 0);
    time_now = 16'h1000;
    cyc("t5_ring", RING, 1, 1, 16'h1000, 0);

    // 6: disable while ringing, async reset in snooze
    enable = 1'b0;
    cyc("t6_off", IDLE, 0, 0, 16'h1000, 0);
    cyc("t6_offhold", IDLE, 0, 0, 16'h1000, 0);
    enable = 1'b1;
    cyc("t6_on", ARMED, 0, 0, 16'h1000, 0);
    cyc("t6_onhold", ARMED, 0, 0, 16'h1000, 0);
    time_now = 16'h1001;
    cyc("t6_away", ARMED, 0, 0, 16'h1000, 0);
    time_now = 16'h1000;
    cyc("t6_ring", RING, 1, 1, 16'h1000, 0);
    push_snooze = 1'b1;
    cyc("t6_snz", SNZ, 0, 0, 16'h1005, 0);
    #2;
    resetn = 1'b0;
    #1;
    chk_all("t6_async", IDLE, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    cyc("t6_post", IDLE, 0, 0, 16'h0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
